// File: rtl/dp_bram_be_if.sv
// Port bundle for dp_bram_be: two byte-enabled access ports plus clear-engine
// and collision status.
interface dp_bram_be_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned DEPTH  = 16384
);
    localparam int unsigned NB = WIDTH / BYTE_W;
    localparam int unsigned AW = $clog2(DEPTH);

    logic             ena;
    logic [NB-1:0]    wea;
    logic [AW-1:0]    addra;
    logic [WIDTH-1:0] dina;
    logic [WIDTH-1:0] douta;
    logic             vala;

    logic             enb;
    logic [NB-1:0]    web;
    logic [AW-1:0]    addrb;
    logic [WIDTH-1:0] dinb;
    logic [WIDTH-1:0] doutb;
    logic             valb;

    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;
    logic             collision;

    modport master (
        output ena, wea, addra, dina,
        output enb, web, addrb, dinb,
        output clr_req,
        input  douta, vala, doutb, valb,
        input  clr_busy, clr_done, collision
    );

    modport slave (
        input  ena, wea, addra, dina,
        input  enb, web, addrb, dinb,
        input  clr_req,
        output douta, vala, doutb, valb,
        output clr_busy, clr_done, collision
    );
endinterface

// File: rtl/dp_bram_be.sv
// Single-clock true-dual-port RAM with byte enables, 1- or 2-cycle read latency,
// read-during-write mode, write/write collision flag and a hardware clear sweep.
module dp_bram_be #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      BYTE_W      = 8,
  parameter int unsigned      DEPTH       = 16384,
  parameter int unsigned      RD_LAT      = 1,
  parameter int unsigned      WRITE_FIRST = 0,
  parameter logic [WIDTH-1:0] CLR_VALUE   = '0,
  parameter                   INIT_FILE   = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  dp_bram_be_if.slave  bus
);
  localparam int unsigned NB       = WIDTH / BYTE_W;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("dp_bram_be: RD_LAT must be 1 or 2");
    end
    if (WIDTH % BYTE_W != 0) begin : g_bad_width
      $error("dp_bram_be: WIDTH must be a multiple of BYTE_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  clr_state_t state, state_next;
  logic [AW:0] cnt, cnt_next;
  logic        clr_wr;
  logic        busy;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            en, act, in_range;
  logic [1:0][NB-1:0]    we, we_eff;
  logic [1:0][AW-1:0]    addr;
  logic [1:0][WIDTH-1:0] din, rd_word;
  logic                  coll_hit;

  logic [1:0]            s1_val, src_val, out_val;
  logic [1:0][WIDTH-1:0] s1_data, src_data, out_data;
  logic                  coll_q;

  assign busy = (state == CLEAR);

  always_comb begin
    en   = {bus.enb, bus.ena};
    we   = {bus.web, bus.wea};
    addr = {bus.addrb, bus.addra};
    din  = {bus.dinb, bus.dina};
    act      = '0;
    in_range = '0;
    we_eff   = '0;
    rd_word  = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      in_range[p] = ({1'b0, addr[p]} < DEPTH_W);
      act[p]      = en[p] & ~busy;
      if (act[p] && in_range[p]) begin
        we_eff[p]  = we[p];
        rd_word[p] = mem[addr[p]];
      end
      // Write-first merges only this port's own lanes; the other port's write is invisible.
      for (int unsigned i = 0; i < NB; i++) begin
        if (WRITE_FIRST != 0 && we_eff[p][i]) begin
          rd_word[p][i*BYTE_W +: BYTE_W] = din[p][i*BYTE_W +: BYTE_W];
        end
      end
    end
    coll_hit = (addr[0] == addr[1]) && (|(we_eff[0] & we_eff[1]));
  end

  always_comb begin
    src_val  = (RD_LAT == 1) ? act     : s1_val;
    src_data = (RD_LAT == 1) ? rd_word : s1_data;
  end

  // Port B lanes are written first so port A wins on overlapping lanes.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[cnt[AW-1:0]] <= CLR_VALUE;
    end
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_eff[1][i]) begin
        mem[addr[1]][i*BYTE_W +: BYTE_W] <= din[1][i*BYTE_W +: BYTE_W];
      end
    end
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_eff[0][i]) begin
        mem[addr[0]][i*BYTE_W +: BYTE_W] <= din[0][i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val   <= '0;
      s1_data  <= '0;
      out_val  <= '0;
      out_data <= '0;
      coll_q   <= 1'b0;
    end else begin
      s1_val  <= act;
      out_val <= src_val;
      coll_q  <= coll_hit;
      for (int unsigned p = 0; p < 2; p++) begin
        if (act[p]) begin
          s1_data[p] <= rd_word[p];
        end
        if (src_val[p]) begin
          out_data[p] <= src_data[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        clr_wr   = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.douta     = out_data[0];
  assign bus.vala      = out_val[0];
  assign bus.doutb     = out_data[1];
  assign bus.valb      = out_val[1];
  assign bus.clr_busy  = busy;
  assign bus.clr_done  = (state == DONE);
  assign bus.collision = coll_q;
endmodule

// File: tb/tb_dp_bram_be.sv
// Directed bench for dp_bram_be: vector table on a 1-cycle/read-first instance,
// latency and read-during-write on 2-cycle instances, then clear-sweep sequences.
module tb_dp_bram_be;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] CLRV = 32'h5A5A0F0F;

    dp_bram_be_if #(.WIDTH(32), .BYTE_W(8), .DEPTH(16)) bus0 ();
    dp_bram_be_if #(.WIDTH(32), .BYTE_W(8), .DEPTH(12)) bus1 ();
    dp_bram_be_if #(.WIDTH(32), .BYTE_W(8), .DEPTH(12)) bus2 ();

    dp_bram_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .RD_LAT(1), .WRITE_FIRST(0),
                 .CLR_VALUE(CLRV)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    dp_bram_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(12), .RD_LAT(2), .WRITE_FIRST(1))
                 dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    dp_bram_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(12), .RD_LAT(2), .WRITE_FIRST(0))
                 dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    typedef struct {
        logic        ea; logic [3:0] wa; logic [3:0] aa; logic [31:0] da;
        logic        eb; logic [3:0] wb; logic [3:0] ab; logic [31:0] db;
        logic        xva; logic [31:0] xda;
        logic        xvb; logic [31:0] xdb;
        logic        xcol;
    } vec_t;

    vec_t vt [15];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.ena = 1'b0; bus0.wea = '0; bus0.addra = '0; bus0.dina = '0;
        bus0.enb = 1'b0; bus0.web = '0; bus0.addrb = '0; bus0.dinb = '0;
        bus0.clr_req = 1'b0;
        bus1.ena = 1'b0; bus1.wea = '0; bus1.addra = '0; bus1.dina = '0;
        bus1.enb = 1'b0; bus1.web = '0; bus1.addrb = '0; bus1.dinb = '0;
        bus1.clr_req = 1'b0;
        bus2.ena = 1'b0; bus2.wea = '0; bus2.addra = '0; bus2.dina = '0;
        bus2.enb = 1'b0; bus2.web = '0; bus2.addrb = '0; bus2.dinb = '0;
        bus2.clr_req = 1'b0;
    endtask

    task automatic l2_drive(input logic en, input logic [3:0] we, input logic [3:0] a,
                            input logic [31:0] d);
        bus1.ena = en; bus1.wea = we; bus1.addra = a; bus1.dina = d;
        bus2.ena = en; bus2.wea = we; bus2.addra = a; bus2.dina = d;
    endtask

    task automatic a_write(input logic [3:0] a, input logic [31:0] d);
        bus0.ena = 1'b1; bus0.wea = 4'hF; bus0.addra = a; bus0.dina = d;
        step();
        bus0.ena = 1'b0; bus0.wea = '0;
    endtask

    task automatic a_read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus0.ena = 1'b1; bus0.wea = '0; bus0.addra = a;
        step();
        bus0.ena = 1'b0;
        check(name, bus0.douta, exp);
    endtask

    initial begin
        int busy_cyc;
        logic saw_done;

        vt[0]  = '{1'b1, 4'hF, 4'd3,  32'hFFFFFFFF, 1'b0, 4'h0, 4'd0,  32'h0,
                   1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vt[1]  = '{1'b1, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'h0, 4'd0,  32'h0,
                   1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
        vt[2]  = '{1'b1, 4'h0, 4'd3,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,
                   1'b1, 32'hFF22FF44, 1'b0, 32'h00000000, 1'b0};
        vt[3]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,
                   1'b0, 32'hFF22FF44, 1'b0, 32'h00000000, 1'b0};
        vt[4]  = '{1'b1, 4'h1, 4'd7,  32'h000000AA, 1'b1, 4'h3, 4'd7,  32'h0000BBCC,
                   1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vt[5]  = '{1'b1, 4'h0, 4'd7,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,
                   1'b1, 32'h0000BBAA, 1'b0, 32'h00000000, 1'b0};
        vt[6]  = '{1'b1, 4'h3, 4'd8,  32'h00001122, 1'b1, 4'hC, 4'd8,  32'h33440000,
                   1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
        vt[7]  = '{1'b1, 4'hF, 4'd8,  32'hDEADBEEF, 1'b1, 4'h0, 4'd8,  32'h0,
                   1'b1, 32'h33441122, 1'b1, 32'h33441122, 1'b0};
        vt[8]  = '{1'b1, 4'h0, 4'd8,  32'h0,        1'b1, 4'h0, 4'd7,  32'h0,
                   1'b1, 32'hDEADBEEF, 1'b1, 32'h0000BBAA, 1'b0};
        vt[9]  = '{1'b1, 4'hF, 4'd9,  32'hAAAAAAAA, 1'b1, 4'hF, 4'd9,  32'hBBBBBBBB,
                   1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vt[10] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'h0, 4'd9,  32'h0,
                   1'b0, 32'h00000000, 1'b1, 32'hAAAAAAAA, 1'b0};
        vt[11] = '{1'b1, 4'hF, 4'd10, 32'h11111111, 1'b1, 4'hF, 4'd11, 32'h22222222,
                   1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
        vt[12] = '{1'b1, 4'h0, 4'd11, 32'h0,        1'b1, 4'h0, 4'd10, 32'h0,
                   1'b1, 32'h22222222, 1'b1, 32'h11111111, 1'b0};
        vt[13] = '{1'b1, 4'h6, 4'd12, 32'h00CCDD00, 1'b1, 4'hC, 4'd12, 32'hEE990000,
                   1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vt[14] = '{1'b1, 4'h0, 4'd12, 32'h0,        1'b0, 4'h0, 4'd0,  32'h0,
                   1'b1, 32'hEECCDD00, 1'b0, 32'h00000000, 1'b0};

        idle_all();
        step();
        step();
        check("rst_douta", bus0.douta, 32'h0);
        check("rst_vala", bus0.vala, 1'b0);
        check("rst_doutb", bus0.doutb, 32'h0);
        check("rst_valb", bus0.valb, 1'b0);
        check("rst_busy", bus0.clr_busy, 1'b0);
        check("rst_done", bus0.clr_done, 1'b0);
        check("rst_coll", bus0.collision, 1'b0);
        check("rst_lat2_val", bus1.vala, 1'b0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) a_write(4'(i), 32'h0);
        step();

        for (int i = 0; i < 15; i++) begin
            bus0.ena = vt[i].ea; bus0.wea = vt[i].wa; bus0.addra = vt[i].aa; bus0.dina = vt[i].da;
            bus0.enb = vt[i].eb; bus0.web = vt[i].wb; bus0.addrb = vt[i].ab; bus0.dinb = vt[i].db;
            step();
            check($sformatf("v%0d_vala", i), bus0.vala, vt[i].xva);
            check($sformatf("v%0d_douta", i), bus0.douta, vt[i].xda);
            check($sformatf("v%0d_valb", i), bus0.valb, vt[i].xvb);
            check($sformatf("v%0d_doutb", i), bus0.doutb, vt[i].xdb);
            check($sformatf("v%0d_coll", i), bus0.collision, vt[i].xcol);
        end
        idle_all();
        step();

        // Read latency 2: write-first vs read-first on the same-port read-during-write.
        l2_drive(1'b1, 4'hF, 4'd5, 32'hAAAAAAAA); step();
        l2_drive(1'b1, 4'h3, 4'd5, 32'h12345678); step();
        l2_drive(1'b0, 4'h0, 4'd0, 32'h0);        step();
        check("wf1_val", bus1.vala, 1'b1);
        check("wf1_dout", bus1.douta, 32'hAAAA5678);
        check("wf0_val", bus2.vala, 1'b1);
        check("wf0_dout", bus2.douta, 32'hAAAAAAAA);
        step();
        check("wf1_val_drop", bus1.vala, 1'b0);
        check("wf1_dout_hold", bus1.douta, 32'hAAAA5678);
        check("wf0_dout_hold", bus2.douta, 32'hAAAAAAAA);
        l2_drive(1'b1, 4'h0, 4'd5, 32'h0); step();
        l2_drive(1'b0, 4'h0, 4'd0, 32'h0);
        check("lat2_t1_val", bus1.vala, 1'b0);
        step();
        check("lat2_t2_val", bus1.vala, 1'b1);
        check("lat2_t2_dout", bus2.douta, 32'hAAAA5678);
        step();
        check("lat2_t3_val", bus1.vala, 1'b0);
        l2_drive(1'b1, 4'hF, 4'd13, 32'h55555555); step();
        l2_drive(1'b0, 4'h0, 4'd0, 32'h0);         step();
        check("oor_val", bus1.vala, 1'b1);
        check("oor_dout", bus1.douta, 32'h0);
        l2_drive(1'b1, 4'hF, 4'd11, 32'h77777777); step();
        l2_drive(1'b1, 4'h0, 4'd11, 32'h0);        step();
        l2_drive(1'b0, 4'h0, 4'd0, 32'h0);         step();
        check("last_word", bus1.douta, 32'h77777777);

        for (int i = 0; i < 16; i++) a_write(4'(i), 32'hC0DE0000 | 32'(i));
        bus0.clr_req = 1'b1; step(); bus0.clr_req = 1'b0;
        check("clr_busy_start", bus0.clr_busy, 1'b1);
        busy_cyc = 0;
        for (int k = 0; k < 40 && bus0.clr_busy === 1'b1; k++) begin
            busy_cyc++;
            if (k == 8) begin
                bus0.ena = 1'b1; bus0.wea = 4'hF; bus0.addra = 4'd2; bus0.dina = 32'hFFFFFFFF;
            end
            step();
            if (k == 8) begin
                check("clr_ignored_val", bus0.vala, 1'b0);
                bus0.ena = 1'b0; bus0.wea = '0;
            end
        end
        check("clr_busy_cycles", 32'(busy_cyc), 32'd16);
        check("clr_done_pulse", bus0.clr_done, 1'b1);
        step();
        check("clr_done_drop", bus0.clr_done, 1'b0);
        for (int i = 0; i < 16; i++) a_read_check($sformatf("clr_word%0d", i), 4'(i), CLRV);

        for (int i = 0; i < 16; i++) a_write(4'(i), 32'hBEEF0000 | 32'(i));
        bus0.clr_req = 1'b1; step(); bus0.clr_req = 1'b0;
        repeat (8) step();
        check("midrst_busy_pre", bus0.clr_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus0.clr_busy, 1'b0);
        check("midrst_done", bus0.clr_done, 1'b0);
        check("midrst_vala", bus0.vala, 1'b0);
        check("midrst_douta", bus0.douta, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus0.clr_done !== 1'b0 || bus0.clr_busy !== 1'b0) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 1'b0);
        for (int i = 0; i < 16; i++)
            a_read_check($sformatf("midrst_word%0d", i), 4'(i),
                         (i < 8) ? CLRV : (32'hBEEF0000 | 32'(i)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
